neuron_sched: RTL and testbench

Time-multiplexed scheduler for a leaky-integrate neuron layer. Holds the membrane state of `N_NEURONS` neurons in an internal register file and shares one leak/integrate/threshold update datapath among them. Each timestep it accepts one input current per neuron over a valid/ready stream, in neuron order, and emits the timestep's spike vector over a second valid/ready handshake. It sits between the input-current source (encoder or previous layer) and the spike consumer.

---
 rtl/neuron_sched.sv | 156 +++++++++++++++
 tb/tb_neuron_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_sched.sv
// Time-multiplexed leaky-integrate neuron layer scheduler.
// One shared leak/integrate/threshold datapath updates N_NEURONS membrane
// states, one accepted current per cycle, then presents the spike vector.
// Optional feature macro: NEURON_SCHED_REFRACTORY_EN (one refractory bit per
// neuron; a neuron that spiked ignores its next accepted current).
module neuron_sched #(
  parameter int unsigned N_NEURONS  = 8,
  parameter int unsigned W          = 8,
  parameter int unsigned THRESHOLD  = 128,
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_current,
  output logic [$clog2(N_NEURONS)-1:0] in_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_NEURONS-1:0]         out_spikes,
  output logic [15:0]                  out_step
);

  localparam int unsigned IDX_W  = $clog2(N_NEURONS);
  localparam int unsigned STEP_W = 16;

  typedef enum logic {
    ST_ACCEPT  = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_NEURONS-1:0]   spikes_q, spikes_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic [W-1:0]           mem_q [N_NEURONS];
  logic [W-1:0]           mem_d [N_NEURONS];
`ifdef NEURON_SCHED_REFRACTORY_EN
  logic [N_NEURONS-1:0]   refr_q, refr_d;
`endif

  logic [W-1:0]           cur_state;
  logic [W-1:0]           leaked;
  logic [W:0]             sum_wide;
  logic [W-1:0]           sum_sat;
  logic                   fire;
  logic                   in_fire;
  logic                   out_fire;

  // Shared datapath: leak, integrate with saturation, threshold compare
  always_comb begin
    cur_state = mem_q[idx_q];
    leaked    = cur_state - (cur_state >> LEAK_SHIFT);
    sum_wide  = {1'b0, leaked} + {1'b0, in_current};
    sum_sat   = sum_wide[W] ? {W{1'b1}} : sum_wide[W-1:0];
    fire      = (sum_sat >= W'(THRESHOLD));
  end

  // Handshakes are qualified by registered state only
  assign in_ready   = (state_q == ST_ACCEPT);
  assign out_valid  = (state_q == ST_PRESENT);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign in_idx     = idx_q;
  assign out_spikes = spikes_q;
  assign out_step   = step_q;

  // Next-state: frame sequencing, neuron write-back, flush override
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    spikes_d = spikes_q;
    step_d   = step_q;
    mem_d    = mem_q;
`ifdef NEURON_SCHED_REFRACTORY_EN
    refr_d   = refr_q;
`endif

    unique case (state_q)
      ST_ACCEPT: begin
        if (in_fire) begin
`ifdef NEURON_SCHED_REFRACTORY_EN
          if (refr_q[idx_q]) begin
            // Current consumed, update suppressed for one timestep
            mem_d[idx_q]  = '0;
            refr_d[idx_q] = 1'b0;
          end else if (fire) begin
            spikes_d[idx_q] = 1'b1;
            mem_d[idx_q]    = '0;
            refr_d[idx_q]   = 1'b1;
          end else begin
            mem_d[idx_q] = sum_sat;
          end
`else
          if (fire) begin
            spikes_d[idx_q] = 1'b1;
            mem_d[idx_q]    = '0;
          end else begin
            mem_d[idx_q] = sum_sat;
          end
`endif
          if (idx_q == IDX_W'(N_NEURONS - 1)) begin
            idx_d   = '0;
            state_d = ST_PRESENT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PRESENT: begin
        if (out_fire) begin
          spikes_d = '0;
          step_d   = step_q + STEP_W'(1);
          state_d  = ST_ACCEPT;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase

    if (flush) begin
      state_d  = ST_ACCEPT;
      idx_d    = '0;
      spikes_d = '0;
      step_d   = '0;
      for (int i = 0; i < int'(N_NEURONS); i++) mem_d[i] = '0;
`ifdef NEURON_SCHED_REFRACTORY_EN
      refr_d   = '0;
`endif
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ACCEPT;
      idx_q    <= '0;
      spikes_q <= '0;
      step_q   <= '0;
      for (int i = 0; i < int'(N_NEURONS); i++) mem_q[i] <= '0;
`ifdef NEURON_SCHED_REFRACTORY_EN
      refr_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      spikes_q <= spikes_d;
      step_q   <= step_d;
      for (int i = 0; i < int'(N_NEURONS); i++) mem_q[i] <= mem_d[i];
`ifdef NEURON_SCHED_REFRACTORY_EN
      refr_q   <= refr_d;
`endif
    end
  end

endmodule

// File: tb/tb_neuron_sched.sv
// Self-checking bench for neuron_sched with default parameters.
module tb_neuron_sched;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_current;
  logic [2:0] in_idx;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_spikes;
  logic [15:0] out_step;

  neuron_sched dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_current(in_current),
    .in_idx(in_idx), .out_valid(out_valid), .out_ready(out_ready),
    .out_spikes(out_spikes), .out_step(out_step)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: per-neuron membrane value, refractory flag, frame info
  int m_state [N];
  bit m_refr  [N];
  int m_idx;
  int m_step;
  int m_spk;
  int cur_a   [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0;
      m_refr[i]  = 1'b0;
    end
    m_idx = 0; m_step = 0; m_spk = 0;
  endtask

  task automatic model_update(input int n, input int c);
    int sum;
`ifdef NEURON_SCHED_REFRACTORY_EN
    if (m_refr[n]) begin
      m_refr[n]  = 1'b0;
      m_state[n] = 0;
      return;
    end
`endif
    sum = m_state[n] - m_state[n] / 8 + c;
    if (sum > 255) sum = 255;
    if (sum >= 128) begin
      m_spk      = m_spk | (1 << n);
      m_state[n] = 0;
      m_refr[n]  = 1'b1;
    end else begin
      m_state[n] = sum;
    end
  endtask

  // One accepted current; entered and left at a falling edge
  task automatic send(input int c);
    chk("in_ready_acc", 32'(in_ready), 32'd1);
    chk("in_idx", 32'(in_idx), 32'(m_idx));
    in_valid   = 1'b1;
    in_current = 8'(c);
    @(negedge clk);
    in_valid = 1'b0;
    model_update(m_idx, c);
    m_idx = (m_idx + 1) % N;
  endtask

  task automatic check_present();
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("in_ready_pres", 32'(in_ready), 32'd0);
    chk("out_spikes", 32'(out_spikes), 32'(m_spk));
    chk("out_step", 32'(out_step), 32'(m_step));
  endtask

  // Full frame from cur_a, present with 'hold' stalled cycles, then handshake
  task automatic frame(input int hold);
    for (int i = 0; i < N; i++) send(cur_a[i]);
    check_present();
    for (int h = 0; h < hold; h++) begin
      in_valid   = 1'b1;
      in_current = 8'($urandom_range(0, 255));
      @(negedge clk);
      check_present();
      chk("in_idx_hold", 32'(in_idx), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    m_step = (m_step + 1) & 32'hFFFF;
    m_spk  = 0;
    chk("in_ready_back", 32'(in_ready), 32'd1);
    chk("out_valid_back", 32'(out_valid), 32'd0);
    chk("in_idx_back", 32'(in_idx), 32'd0);
    chk("out_spikes_clr", 32'(out_spikes), 32'd0);
  endtask

  task automatic set_cur(input int n, input int v);
    for (int i = 0; i < N; i++) cur_a[i] = 0;
    cur_a[n] = v;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_current = '0;
    model_clear();
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_idx", 32'(in_idx), 32'd0);
    chk("rst_out_spikes", 32'(out_spikes), 32'd0);
    chk("rst_out_step", 32'(out_step), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero frame
    for (int i = 0; i < N; i++) cur_a[i] = 0;
    frame(0);

    // Neuron 0: 100 then 50 -> 100-12+50=138 spikes in step 1
    do_flush();
    set_cur(0, 100);
    for (int i = 0; i < N; i++) send(cur_a[i]);
    chk("tp0_nospike", 32'(out_spikes), 32'h00);
    chk("tp0_step", 32'(out_step), 32'd0);
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    m_step = 1; m_spk = 0;
    set_cur(0, 50);
    for (int i = 0; i < N; i++) send(cur_a[i]);
    chk("tp1_spike0", 32'(out_spikes), 32'h01);
    chk("tp1_step", 32'(out_step), 32'd1);
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    m_step = 2; m_spk = 0;

    // Neuron 3: 100 then 255 saturates and spikes; stall present 5 cycles
    set_cur(3, 100);
    frame(0);
    set_cur(3, 255);
    for (int i = 0; i < N; i++) send(cur_a[i]);
    chk("sat_spike3", 32'(out_spikes), 32'h08);
    m_idx = 0;
    for (int h = 0; h < 5; h++) begin
      in_valid = 1'b1; in_current = 8'd200;
      @(negedge clk);
      check_present();
      chk("in_idx_stall", 32'(in_idx), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    m_step = (m_step + 1) & 32'hFFFF; m_spk = 0;
    chk("stall_release", 32'(in_ready), 32'd1);
    chk("stall_idx", 32'(in_idx), 32'd0);
    // Neuron 3 must have been cleared, not wrapped
    set_cur(3, 120);
    frame(0);

    // Randomized frames with random present stalls
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < N; i++) cur_a[i] = int'($urandom_range(0, 255));
      frame(int'($urandom_range(0, 3)));
    end

    // Flush mid-frame together with a valid current
    for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 255)));
    chk("pre_flush_idx", 32'(in_idx), 32'd4);
    flush = 1'b1; in_valid = 1'b1; in_current = 8'd77;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    model_clear();
    chk("flush_idx", 32'(in_idx), 32'd0);
    chk("flush_step", 32'(out_step), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < N; i++) cur_a[i] = 90;
    frame(0);

    // Flush coinciding with the output handshake: step not counted
    for (int i = 0; i < N; i++) send(200);
    check_present();
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    model_clear();
    chk("flushout_step", 32'(out_step), 32'd0);
    chk("flushout_valid", 32'(out_valid), 32'd0);
    chk("flushout_spikes", 32'(out_spikes), 32'd0);

    // Some history, then asynchronous reset mid-frame
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) cur_a[i] = int'($urandom_range(0, 255));
      frame(0);
    end
    for (int i = 0; i < 3; i++) send(int'($urandom_range(0, 255)));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_idx", 32'(in_idx), 32'd0);
    chk("arst_step", 32'(out_step), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < N; i++) cur_a[i] = 60;
    frame(0);

    // Refractory behaviour on neuron 0 with current 200 three steps running
    do_flush();
    set_cur(0, 200);
    frame(0);
`ifdef NEURON_SCHED_REFRACTORY_EN
    for (int i = 0; i < N; i++) send(cur_a[i]);
    chk("refr_suppress", 32'(out_spikes), 32'h00);
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    m_step = (m_step + 1) & 32'hFFFF; m_spk = 0;
    for (int i = 0; i < N; i++) send(cur_a[i]);
    chk("refr_respike", 32'(out_spikes), 32'h01);
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    m_step = (m_step + 1) & 32'hFFFF; m_spk = 0;
`else
    for (int i = 0; i < N; i++) send(cur_a[i]);
    chk("norefr_spike", 32'(out_spikes), 32'h01);
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    m_step = (m_step + 1) & 32'hFFFF; m_spk = 0;
`endif
    frame(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
